// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit five-stage CPU pipeline.
// Provides special-register selects, ALU opcodes, ID/EX state and the bubble control word.
package cpu_pkg;

  localparam logic [1:0] SPEC_NONE = 2'b00;
  localparam logic [1:0] SPEC_T    = 2'b01;
  localparam logic [1:0] SPEC_SP   = 2'b10;
  localparam logic [1:0] SPEC_IH   = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRA = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_PASS_B = 4'd8;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BUBBLE  = 2'd1,
    FLUSHED = 2'd2
  } idex_state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] write_spec;
  } ctrl_t;

  // A bubble must look like a NOP to forwarding and memory: nothing written, nothing accessed.
  localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                    write_spec: SPEC_NONE};

  function automatic logic spec_hit(input logic [1:0] wr_spec, input logic [1:0] rd_spec);
    return (wr_spec != SPEC_NONE) && (wr_spec == rd_spec);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector comparing the load in EX against the operands read in ID.
// A hit on either a general register or a matching special register requests one bubble.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int REG_ID_W = 3
) (
  input  logic                i_valid_ex,
  input  logic                i_mem_read_ex,
  input  logic                i_reg_write_ex,
  input  logic [REG_ID_W-1:0] i_wr_id_ex,
  input  logic [1:0]          i_wr_spec_ex,
  input  logic [REG_ID_W-1:0] i_rx_id,
  input  logic [REG_ID_W-1:0] i_ry_id,
  input  logic                i_uses_rx,
  input  logic                i_uses_ry,
  input  logic [1:0]          i_rd_spec_id,
  output logic                o_lu
);

  logic w_gpr_hit;
  logic w_spec_hit;

  assign w_gpr_hit  = i_valid_ex & i_mem_read_ex & i_reg_write_ex &
                      ((i_uses_rx & (i_rx_id == i_wr_id_ex)) |
                       (i_uses_ry & (i_ry_id == i_wr_id_ex)));
  assign w_spec_hit = i_mem_read_ex & spec_hit(i_wr_spec_ex, i_rd_spec_id);
  assign o_lu       = w_gpr_hit | w_spec_hit;

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble, flush squash and PC/IF-ID stall generation.
// Optional HAZARD_STATS_EN adds saturating stallCount/flushCount outputs.
module idex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_ID_W = 3,
  parameter int ALUOP_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                flush,
  input  logic [REG_ID_W-1:0] rx_id,
  input  logic [REG_ID_W-1:0] ry_id,
  input  logic [REG_ID_W-1:0] rz_id,
  input  logic                regWrite_id,
  input  logic [REG_ID_W-1:0] registerToWriteId_id,
  input  logic [1:0]          writeSpecReg_id,
  input  logic [1:0]          readSpecReg_id,
  input  logic                memRead_id,
  input  logic                memWrite_id,
  input  logic [ALUOP_W-1:0]  aluOp_id,
  input  logic [DATA_W-1:0]   data1_id,
  input  logic [DATA_W-1:0]   data2_id,
  input  logic [DATA_W-1:0]   imm_id,
  input  logic [DATA_W-1:0]   pc_id,
  input  logic                uses_rx_id,
  input  logic                uses_ry_id,
  output logic [REG_ID_W-1:0] Rx_a_IDEX,
  output logic [REG_ID_W-1:0] Ry_a_IDEX,
  output logic [REG_ID_W-1:0] Rz_a_IDEX,
  output logic                regWrite_a_IDEX,
  output logic [REG_ID_W-1:0] registerToWriteId_a_IDEX,
  output logic [1:0]          writeSpecReg_a_IDEX,
  output logic [1:0]          readSpecReg_a_IDEX,
  output logic                memRead_a_IDEX,
  output logic                memWrite_a_IDEX,
  output logic [ALUOP_W-1:0]  aluOp_a_IDEX,
  output logic [DATA_W-1:0]   data1_a_IDEX,
  output logic [DATA_W-1:0]   data2_a_IDEX,
  output logic [DATA_W-1:0]   imm_a_IDEX,
  output logic [DATA_W-1:0]   pc_a_IDEX,
  output logic                uses_rx_a_IDEX,
  output logic                uses_ry_a_IDEX,
  output logic                valid_IDEX,
  output logic                stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]         stallCount,
  output logic [15:0]         flushCount
`endif
);

  idex_state_e         r_state;
  idex_state_e         w_state_nxt;
  ctrl_t               r_ctrl;
  logic [REG_ID_W-1:0] r_rx;
  logic [REG_ID_W-1:0] r_ry;
  logic [REG_ID_W-1:0] r_rz;
  logic [REG_ID_W-1:0] r_wr_id;
  logic [1:0]          r_rd_spec;
  logic [ALUOP_W-1:0]  r_alu_op;
  logic [DATA_W-1:0]   r_data1;
  logic [DATA_W-1:0]   r_data2;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_pc;
  logic                r_uses_rx;
  logic                r_uses_ry;
  logic                r_valid;

  logic                w_lu;
  logic                w_load_bubble;
  logic                w_lu_stall;

  hazard_detect #(
    .REG_ID_W(REG_ID_W)
  ) u_hazard_detect (
    .i_valid_ex    (r_valid),
    .i_mem_read_ex (r_ctrl.mem_read),
    .i_reg_write_ex(r_ctrl.reg_write),
    .i_wr_id_ex    (r_wr_id),
    .i_wr_spec_ex  (r_ctrl.write_spec),
    .i_rx_id       (rx_id),
    .i_ry_id       (ry_id),
    .i_uses_rx     (uses_rx_id),
    .i_uses_ry     (uses_ry_id),
    .i_rd_spec_id  (readSpecReg_id),
    .o_lu          (w_lu)
  );

  // Hold is applied in the register process; this decides what the next edge loads.
  always_comb begin
    w_state_nxt   = RUN;
    w_load_bubble = 1'b0;
    w_lu_stall    = 1'b0;
    if (flush) begin
      w_load_bubble = 1'b1;
      w_state_nxt   = FLUSHED;
    end else begin
      case (r_state)
        RUN: begin
          if (w_lu) begin
            w_load_bubble = 1'b1;
            w_lu_stall    = 1'b1;
            w_state_nxt   = BUBBLE;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= RUN;
      r_ctrl    <= CTRL_BUBBLE;
      r_rx      <= '0;
      r_ry      <= '0;
      r_rz      <= '0;
      r_wr_id   <= '0;
      r_rd_spec <= '0;
      r_alu_op  <= '0;
      r_data1   <= '0;
      r_data2   <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_uses_rx <= 1'b0;
      r_uses_ry <= 1'b0;
      r_valid   <= 1'b0;
    end else if (!hold) begin
      r_state <= w_state_nxt;
      if (w_load_bubble) begin
        r_ctrl    <= CTRL_BUBBLE;
        r_rx      <= '0;
        r_ry      <= '0;
        r_rz      <= '0;
        r_wr_id   <= '0;
        r_rd_spec <= '0;
        r_alu_op  <= '0;
        r_data1   <= '0;
        r_data2   <= '0;
        r_imm     <= '0;
        r_pc      <= '0;
        r_uses_rx <= 1'b0;
        r_uses_ry <= 1'b0;
        r_valid   <= 1'b0;
      end else begin
        r_ctrl    <= '{reg_write: regWrite_id, mem_read: memRead_id,
                       mem_write: memWrite_id, write_spec: writeSpecReg_id};
        r_rx      <= rx_id;
        r_ry      <= ry_id;
        r_rz      <= rz_id;
        r_wr_id   <= registerToWriteId_id;
        r_rd_spec <= readSpecReg_id;
        r_alu_op  <= aluOp_id;
        r_data1   <= data1_id;
        r_data2   <= data2_id;
        r_imm     <= imm_id;
        r_pc      <= pc_id;
        r_uses_rx <= uses_rx_id;
        r_uses_ry <= uses_ry_id;
        r_valid   <= 1'b1;
      end
    end
  end

  // Gated by reset so upstream stages never see a stall while the pipe is being cleared.
  assign stall = rst & (hold | w_lu_stall);

  assign Rx_a_IDEX                = r_rx;
  assign Ry_a_IDEX                = r_ry;
  assign Rz_a_IDEX                = r_rz;
  assign regWrite_a_IDEX          = r_ctrl.reg_write;
  assign registerToWriteId_a_IDEX = r_wr_id;
  assign writeSpecReg_a_IDEX      = r_ctrl.write_spec;
  assign readSpecReg_a_IDEX       = r_rd_spec;
  assign memRead_a_IDEX           = r_ctrl.mem_read;
  assign memWrite_a_IDEX          = r_ctrl.mem_write;
  assign aluOp_a_IDEX             = r_alu_op;
  assign data1_a_IDEX             = r_data1;
  assign data2_a_IDEX             = r_data2;
  assign imm_a_IDEX               = r_imm;
  assign pc_a_IDEX                = r_pc;
  assign uses_rx_a_IDEX           = r_uses_rx;
  assign uses_ry_a_IDEX           = r_uses_ry;
  assign valid_IDEX               = r_valid;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!hold) begin
      if (w_lu_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (flush && (r_flush_cnt != 16'hFFFF))      r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stallCount = r_stall_cnt;
  assign flushCount = r_flush_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Scoreboard bench for idex_stage: stimulus pushes expected per-cycle state, a monitor pops and compares.
module tb_idex_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [2:0]  rz;
    logic        rw;
    logic [2:0]  wd;
    logic [1:0]  wsr;
    logic [1:0]  rsr;
    logic        mr;
    logic        mw;
    logic [3:0]  op;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        urx;
    logic        ury;
  } id_t;

  typedef struct packed {
    logic        stall;
    logic        valid;
    id_t         r;
`ifdef HAZARD_STATS_EN
    logic [15:0] sc;
    logic [15:0] fc;
`endif
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hold = 1'b0;
  logic flush = 1'b0;
  id_t  cin = '0;

  logic [2:0]  Rx_a_IDEX, Ry_a_IDEX, Rz_a_IDEX, registerToWriteId_a_IDEX;
  logic        regWrite_a_IDEX, memRead_a_IDEX, memWrite_a_IDEX;
  logic [1:0]  writeSpecReg_a_IDEX, readSpecReg_a_IDEX;
  logic [3:0]  aluOp_a_IDEX;
  logic [15:0] data1_a_IDEX, data2_a_IDEX, imm_a_IDEX, pc_a_IDEX;
  logic        uses_rx_a_IDEX, uses_ry_a_IDEX, valid_IDEX, stall;
`ifdef HAZARD_STATS_EN
  logic [15:0] stallCount, flushCount;
`endif

  always #5 clk = ~clk;

  idex_stage dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .rx_id(cin.rx), .ry_id(cin.ry), .rz_id(cin.rz),
    .regWrite_id(cin.rw), .registerToWriteId_id(cin.wd),
    .writeSpecReg_id(cin.wsr), .readSpecReg_id(cin.rsr),
    .memRead_id(cin.mr), .memWrite_id(cin.mw), .aluOp_id(cin.op),
    .data1_id(cin.d1), .data2_id(cin.d2), .imm_id(cin.imm), .pc_id(cin.pc),
    .uses_rx_id(cin.urx), .uses_ry_id(cin.ury),
    .Rx_a_IDEX(Rx_a_IDEX), .Ry_a_IDEX(Ry_a_IDEX), .Rz_a_IDEX(Rz_a_IDEX),
    .regWrite_a_IDEX(regWrite_a_IDEX), .registerToWriteId_a_IDEX(registerToWriteId_a_IDEX),
    .writeSpecReg_a_IDEX(writeSpecReg_a_IDEX), .readSpecReg_a_IDEX(readSpecReg_a_IDEX),
    .memRead_a_IDEX(memRead_a_IDEX), .memWrite_a_IDEX(memWrite_a_IDEX),
    .aluOp_a_IDEX(aluOp_a_IDEX), .data1_a_IDEX(data1_a_IDEX), .data2_a_IDEX(data2_a_IDEX),
    .imm_a_IDEX(imm_a_IDEX), .pc_a_IDEX(pc_a_IDEX),
    .uses_rx_a_IDEX(uses_rx_a_IDEX), .uses_ry_a_IDEX(uses_ry_a_IDEX),
    .valid_IDEX(valid_IDEX), .stall(stall)
`ifdef HAZARD_STATS_EN
    , .stallCount(stallCount), .flushCount(flushCount)
`endif
  );

  // Reference model: what ID/EX should hold, derived directly from the hazard rules.
  exp_t        sbq[$];
  logic        m_valid = 1'b0;
  id_t         m_r = '0;
`ifdef HAZARD_STATS_EN
  logic [15:0] m_sc = '0;
  logic [15:0] m_fc = '0;
`endif
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;

  task automatic fail_line(input string name, input logic [127:0] got, input logic [127:0] want);
    n_fail++;
    $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, want);
  endtask

  task automatic step(input logic r, input logic h, input logic f, input id_t v, output logic st);
    exp_t e;
    logic lu;
    @(posedge clk);
    #1;
    rst = r; hold = h; flush = f; cin = v;
    lu = (m_valid && m_r.mr && m_r.rw &&
          ((v.urx && v.rx == m_r.wd) || (v.ury && v.ry == m_r.wd))) ||
         (m_r.mr && m_r.wsr != 2'b00 && m_r.wsr == v.rsr);
    e.stall = r && (h || (lu && !f));
    e.valid = m_valid;
    e.r     = m_r;
`ifdef HAZARD_STATS_EN
    e.sc = m_sc;
    e.fc = m_fc;
`endif
    sbq.push_back(e);
    if (!r) begin
      m_valid = 1'b0; m_r = '0;
`ifdef HAZARD_STATS_EN
      m_sc = '0; m_fc = '0;
`endif
    end else if (!h) begin
      if (f || lu) begin
        m_valid = 1'b0;
        m_r     = '0;
`ifdef HAZARD_STATS_EN
        if (f && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        if (!f && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
`endif
      end else begin
        m_valid = 1'b1;
        m_r     = v;
      end
    end
    st = e.stall;
  endtask

  function automatic id_t rnd_id();
    id_t v;
    v.rx  = 3'($urandom_range(0, 3));
    v.ry  = 3'($urandom_range(0, 3));
    v.rz  = 3'($urandom_range(0, 7));
    v.rw  = 1'($urandom_range(0, 1));
    v.wd  = 3'($urandom_range(0, 3));
    v.wsr = 2'($urandom_range(0, 3));
    v.rsr = 2'($urandom_range(0, 3));
    v.mr  = ($urandom_range(0, 2) == 0);
    v.mw  = 1'($urandom_range(0, 1));
    v.op  = 4'($urandom_range(0, 15));
    v.d1  = 16'($urandom);
    v.d2  = 16'($urandom);
    v.imm = 16'($urandom);
    v.pc  = 16'($urandom);
    v.urx = 1'($urandom_range(0, 1));
    v.ury = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic id_t mk_load(input logic [2:0] dest);
    id_t v = rnd_id();
    v.mr = 1'b1; v.rw = 1'b1; v.wd = dest; v.mw = 1'b0; v.wsr = SPEC_NONE;
    v.urx = 1'b0; v.ury = 1'b0; v.rsr = SPEC_NONE;
    return v;
  endfunction

  function automatic id_t mk_alu(input logic [2:0] rx, input logic urx, input logic [2:0] dest);
    id_t v = rnd_id();
    v.mr = 1'b0; v.mw = 1'b0; v.rw = 1'b1; v.wd = dest; v.wsr = SPEC_NONE; v.rsr = SPEC_NONE;
    v.rx = rx; v.urx = urx; v.ry = 3'd6; v.ury = 1'b1; v.op = ALU_ADD;
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    id_t  g;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      g = '{rx: Rx_a_IDEX, ry: Ry_a_IDEX, rz: Rz_a_IDEX, rw: regWrite_a_IDEX,
            wd: registerToWriteId_a_IDEX, wsr: writeSpecReg_a_IDEX, rsr: readSpecReg_a_IDEX,
            mr: memRead_a_IDEX, mw: memWrite_a_IDEX, op: aluOp_a_IDEX,
            d1: data1_a_IDEX, d2: data2_a_IDEX, imm: imm_a_IDEX, pc: pc_a_IDEX,
            urx: uses_rx_a_IDEX, ury: uses_ry_a_IDEX};
      n_tests++;
      if (stall !== e.stall) fail_line("stall", 128'(stall), 128'(e.stall));
      n_tests++;
      if (valid_IDEX !== e.valid) fail_line("valid_IDEX", 128'(valid_IDEX), 128'(e.valid));
      n_tests++;
      if (e.valid) begin
        if (g !== e.r) fail_line("idex_fields", 128'(g), 128'(e.r));
      end else begin
        if ({g.rx, g.ry, g.rz, g.wd, g.rw, g.mr, g.mw, g.wsr} !== 16'h0)
          fail_line("bubble_nop", 128'({g.rx, g.ry, g.rz, g.wd, g.rw, g.mr, g.mw, g.wsr}), 128'(0));
      end
`ifdef HAZARD_STATS_EN
      n_tests++;
      if (stallCount !== e.sc) fail_line("stallCount", 128'(stallCount), 128'(e.sc));
      n_tests++;
      if (flushCount !== e.fc) fail_line("flushCount", 128'(flushCount), 128'(e.fc));
`endif
    end
    cyc++;
  end

  initial begin
    logic st;
    id_t  v;
    id_t  sp_ld;
    id_t  sp_rd;
    // Reset with random inputs.
    rst = 1'b0;
    cin = rnd_id();
    for (int i = 0; i < 2; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_id(), st);

    // Load-use on Rx: stall, bubble, then the dependent op is captured.
    step(1'b1, 1'b0, 1'b0, mk_load(3'd3), st);
    v = mk_alu(3'd3, 1'b1, 3'd5);
    step(1'b1, 1'b0, 1'b0, v, st);
    step(1'b1, 1'b0, 1'b0, v, st);
    step(1'b1, 1'b0, 1'b0, mk_alu(3'd1, 1'b1, 3'd2), st);

    // Same register ID but not actually read: no stall.
    step(1'b1, 1'b0, 1'b0, mk_load(3'd3), st);
    step(1'b1, 1'b0, 1'b0, mk_alu(3'd3, 1'b0, 3'd4), st);
    step(1'b1, 1'b0, 1'b0, mk_alu(3'd0, 1'b1, 3'd4), st);

    // Flush coinciding with a load-use: flush wins, no stall.
    step(1'b1, 1'b0, 1'b0, mk_load(3'd2), st);
    step(1'b1, 1'b0, 1'b1, mk_alu(3'd2, 1'b1, 3'd1), st);
    step(1'b1, 1'b0, 1'b0, mk_alu(3'd2, 1'b1, 3'd1), st);
    step(1'b1, 1'b0, 1'b0, mk_alu(3'd0, 1'b1, 3'd1), st);

    // Hold for three cycles mid-stream, then resume.
    step(1'b1, 1'b0, 1'b0, mk_alu(3'd1, 1'b1, 3'd7), st);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), rnd_id(), st);
    step(1'b1, 1'b0, 1'b0, mk_alu(3'd2, 1'b1, 3'd3), st);

    // Special-register load-use on SP.
    sp_ld = mk_load(3'd0);
    sp_ld.rw = 1'b0; sp_ld.wsr = SPEC_SP;
    sp_rd = mk_alu(3'd0, 1'b0, 3'd0);
    sp_rd.ury = 1'b0; sp_rd.rsr = SPEC_SP;
    step(1'b1, 1'b0, 1'b0, sp_ld, st);
    step(1'b1, 1'b0, 1'b0, sp_rd, st);
    step(1'b1, 1'b0, 1'b0, sp_rd, st);

    // Reset asserted while hold is high.
    step(1'b1, 1'b1, 1'b0, rnd_id(), st);
    step(1'b0, 1'b1, 1'b0, rnd_id(), st);
    step(1'b1, 1'b0, 1'b0, rnd_id(), st);

    // Random traffic; a stalled instruction is presented again, as IF/ID would.
    v = rnd_id();
    for (int i = 0; i < 600; i++) begin
      logic r, h, f;
      r = ($urandom_range(0, 99) != 0);
      h = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 9) == 0);
      step(r, h, f, v, st);
      if (!st || $urandom_range(0, 7) == 0) v = rnd_id();
    end

    repeat (3) @(posedge clk);
    n_tests++;
    if (sbq.size() != 0) fail_line("scoreboard_drain", 128'(sbq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
